// File: rtl/rect_fill_engine.sv
// -----------------------------------------------------------------------------
// rect_fill_engine
//
// Fills an axis-aligned framebuffer rectangle with one 24-bit colour by
// emitting masked 8-pixel write bursts: one address-FIFO push per chunk,
// followed by two 128-bit write-data beats (pixels 0-3, then pixels 4-7).
// The DDR2 request controller supplies the command code, so this block
// drives only the address, data and byte mask.
//
// Parameters:
//   FB_BASE       framebuffer base in 32-bit-pixel units (low 20 bits zero)
//
// Ports:
//   clk, rst                 CPU clock, synchronous active-high reset
//   rect_x0/x1, rect_y0/y1   inclusive rectangle bounds (10 bits each)
//   rect_color               fill colour {R,G,B}
//   rect_valid/rect_ready    command handshake; ready is high only when idle
//   af_full/af_wr_en         address FIFO back-pressure / push
//   af_addr_din              burst address FB_BASE | {row, chunk, 3'b000}
//   wdf_full/wdf_wr_en       write-data FIFO back-pressure / push
//   wdf_din                  write beat, four {8'h00, colour} pixels
//   wdf_mask_din             byte mask, 1 = byte not written
//
// Build option:
//   RECT_FILL_CLIP_EN        when defined, bounds are clipped to the
//                            800x600 visible screen at command accept.
// -----------------------------------------------------------------------------
module rect_fill_engine #(
    parameter logic [30:0] FB_BASE = 31'h0010_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [9:0]   rect_x0,
    input  logic [9:0]   rect_x1,
    input  logic [9:0]   rect_y0,
    input  logic [9:0]   rect_y1,
    input  logic [23:0]  rect_color,
    input  logic         rect_valid,
    output logic         rect_ready,
    input  logic         af_full,
    output logic         af_wr_en,
    output logic [30:0]  af_addr_din,
    input  logic         wdf_full,
    output logic         wdf_wr_en,
    output logic [127:0] wdf_din,
    output logic [15:0]  wdf_mask_din
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AF   = 2'd1,
        S_WD0  = 2'd2,
        S_WD1  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched command
    logic [9:0]  r_x0;
    logic [9:0]  r_x1;
    logic [9:0]  r_y1;
    logic [23:0] r_color;

    // Walk position
    logic [6:0]  r_chunk;
    logic [9:0]  r_row;

    logic        w_accept;
    logic        w_empty;
    logic [9:0]  w_cx1;
    logic [9:0]  w_cy1;
    logic        w_wd_push;
    logic        w_last_chunk;
    logic        w_last_row;

    // Byte mask for one beat: a pixel nibble is written only when its column
    // falls inside [x0, x1]. Column = {chunk, beat, pixel index}.
    function automatic logic [15:0] beat_mask(
        input logic [6:0] chunk,
        input logic       beat,
        input logic [9:0] x0,
        input logic [9:0] x1
    );
        logic [9:0] px;
        beat_mask = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            px = {chunk, beat, 2'(i)};
            if ((px < x0) || (px > x1)) begin
                beat_mask[4*i +: 4] = 4'hF;
            end
        end
    endfunction

    // Bound adjustment and emptiness test on the raw command inputs
    always_comb begin
        w_cx1   = rect_x1;
        w_cy1   = rect_y1;
        w_empty = (rect_x0 > rect_x1) || (rect_y0 > rect_y1);
`ifdef RECT_FILL_CLIP_EN
        if (rect_x1 > 10'd799) begin
            w_cx1 = 10'd799;
        end
        if (rect_y1 > 10'd599) begin
            w_cy1 = 10'd599;
        end
        // x0 beyond the clipped x1 also covers an origin off the screen
        w_empty = (rect_x0 > w_cx1) || (rect_y0 > w_cy1);
`endif
    end

    assign w_accept     = rect_valid && (r_state == S_IDLE);
    assign w_wd_push    = (r_state == S_WD1) && !wdf_full;
    assign w_last_chunk = (r_chunk == r_x1[9:3]);
    assign w_last_row   = (r_row == r_y1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command latch and walk counters; meaningful only outside IDLE, so they
    // carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_x0    <= rect_x0;
            r_x1    <= w_cx1;
            r_y1    <= w_cy1;
            r_color <= rect_color;
            r_chunk <= rect_x0[9:3];
            r_row   <= rect_y0;
        end else if (w_wd_push) begin
            if (!w_last_chunk) begin
                r_chunk <= r_chunk + 7'd1;
            end else begin
                r_chunk <= r_x0[9:3];
                r_row   <= r_row + 10'd1;
            end
        end
    end

    // Next state and outputs
    always_comb begin
        w_state_nxt  = r_state;
        rect_ready   = 1'b0;
        af_wr_en     = 1'b0;
        af_addr_din  = 31'd0;
        wdf_wr_en    = 1'b0;
        wdf_din      = 128'd0;
        wdf_mask_din = 16'hFFFF;

        case (r_state)
            S_IDLE: begin
                rect_ready = 1'b1;
                if (rect_valid && !w_empty) begin
                    w_state_nxt = S_AF;
                end
            end
            S_AF: begin
                af_wr_en    = !af_full;
                af_addr_din = FB_BASE | {11'd0, r_row, r_chunk, 3'b000};
                if (!af_full) begin
                    w_state_nxt = S_WD0;
                end
            end
            S_WD0: begin
                wdf_wr_en    = !wdf_full;
                wdf_din      = {4{8'h00, r_color}};
                wdf_mask_din = beat_mask(r_chunk, 1'b0, r_x0, r_x1);
                if (!wdf_full) begin
                    w_state_nxt = S_WD1;
                end
            end
            S_WD1: begin
                wdf_wr_en    = !wdf_full;
                wdf_din      = {4{8'h00, r_color}};
                wdf_mask_din = beat_mask(r_chunk, 1'b1, r_x0, r_x1);
                if (!wdf_full) begin
                    if (w_last_chunk && w_last_row) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_AF;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;

    localparam logic [30:0] FB = 31'h0010_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   rect_x0, rect_x1, rect_y0, rect_y1;
    logic [23:0]  rect_color;
    logic         rect_valid;
    logic         rect_ready;
    logic         af_full;
    logic         af_wr_en;
    logic [30:0]  af_addr_din;
    logic         wdf_full;
    logic         wdf_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    always #5 clk = ~clk;

    rect_fill_engine #(.FB_BASE(FB)) dut (
        .clk          (clk),
        .rst          (rst),
        .rect_x0      (rect_x0),
        .rect_x1      (rect_x1),
        .rect_y0      (rect_y0),
        .rect_y1      (rect_y1),
        .rect_color   (rect_color),
        .rect_valid   (rect_valid),
        .rect_ready   (rect_ready),
        .af_full      (af_full),
        .af_wr_en     (af_wr_en),
        .af_addr_din  (af_addr_din),
        .wdf_full     (wdf_full),
        .wdf_wr_en    (wdf_wr_en),
        .wdf_din      (wdf_din),
        .wdf_mask_din (wdf_mask_din)
    );

    typedef struct packed {
        logic         is_wd;
        logic [30:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
    } ev_t;

    typedef struct {
        int          x0, x1, y0, y1;
        logic [23:0] col;
        int          mode;
        int          n_af;
        logic [30:0] first_addr;
        logic [15:0] first_mask;
    } vec_t;

    ev_t exp_q[$];
    ev_t act_q[$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  cyc_g = 0;
    int  last_push_cyc = 0;
    int  viol = 0;
    int  n_af_act = 0;
    int  n_wd_act = 0;
    ev_t mon_e;

    always @(posedge clk) cyc_g <= cyc_g + 1;

    // Record every push as seen just before the edge that consumes it
    always @(negedge clk) begin
        if (af_wr_en) begin
            mon_e.is_wd = 1'b0;
            mon_e.addr  = af_addr_din;
            mon_e.data  = 128'd0;
            mon_e.mask  = 16'd0;
            act_q.push_back(mon_e);
            n_af_act++;
            last_push_cyc = cyc_g;
            if (af_full) viol++;
        end
        if (wdf_wr_en) begin
            mon_e.is_wd = 1'b1;
            mon_e.addr  = 31'd0;
            mon_e.data  = wdf_din;
            mon_e.mask  = wdf_mask_din;
            act_q.push_back(mon_e);
            n_wd_act++;
            last_push_cyc = cyc_g;
            if (wdf_full) viol++;
        end
        if (af_wr_en && wdf_wr_en) viol++;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_ev(input int k, input ev_t a, input ev_t e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL event%0d: got wd=%0b addr=%0h mask=%0h data=%0h expected wd=%0b addr=%0h mask=%0h data=%0h",
                      k, a.is_wd, a.addr, a.mask, a.data, e.is_wd, e.addr, e.mask, e.data);
    endtask

    // Reference: every chunk of every row, one address then two beats
    task automatic build_exp(input int x0, input int x1, input int y0, input int y1,
                             input logic [23:0] col);
        ev_t e;
        int  cx1, cy1, x;
        cx1 = x1;
        cy1 = y1;
        exp_q.delete();
`ifdef RECT_FILL_CLIP_EN
        if (cx1 > 799) cx1 = 799;
        if (cy1 > 599) cy1 = 599;
`endif
        if (x0 > cx1 || y0 > cy1) return;
        for (int y = y0; y <= cy1; y++) begin
            for (int c = x0 / 8; c <= cx1 / 8; c++) begin
                e.is_wd = 1'b0;
                e.addr  = FB + 31'(y * 1024 + c * 8);
                e.data  = 128'd0;
                e.mask  = 16'd0;
                exp_q.push_back(e);
                for (int b = 0; b < 2; b++) begin
                    e.is_wd = 1'b1;
                    e.addr  = 31'd0;
                    e.data  = {4{8'h00, col}};
                    e.mask  = 16'd0;
                    for (int i = 0; i < 4; i++) begin
                        x = c * 8 + b * 4 + i;
                        if (x < x0 || x > cx1) e.mask[4*i +: 4] = 4'hF;
                    end
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // mode 0: no back-pressure, 1: 20-cycle AF stall at chunk 2 plus WDF
    // toggling, 2: random back-pressure
    task automatic run_cmd(input int x0, input int x1, input int y0, input int y1,
                           input logic [23:0] col, input int mode, output int base);
        int cyc, budget, scnt, v0, naf0, nwd0, n;
        build_exp(x0, x1, y0, y1, col);
        base = act_q.size();
        v0   = viol;
        naf0 = n_af_act;
        nwd0 = n_wd_act;
        rect_x0 = 10'(x0); rect_x1 = 10'(x1);
        rect_y0 = 10'(y0); rect_y1 = 10'(y1);
        rect_color = col;
        rect_valid = 1'b1;
        @(posedge clk); #1;
        rect_valid = 1'b0;
        rect_x0 = 10'($urandom); rect_x1 = 10'($urandom);
        rect_y0 = 10'($urandom); rect_y1 = 10'($urandom);
        rect_color = 24'($urandom);
        if (exp_q.size() == 0) begin
            repeat (3) begin
                chk("empty_ready_high", 128'(rect_ready), 128'(1));
                @(posedge clk); #1;
            end
        end else begin
            chk("ready_low_after_accept", 128'(rect_ready), 128'(0));
            chk("af_en_after_accept", 128'(af_wr_en), 128'(1));
            budget = exp_q.size() * 8 + 200;
            cyc = 0;
            scnt = 0;
            while (!rect_ready && cyc < budget) begin
                case (mode)
                    1: begin
                        wdf_full = !wdf_full;
                        af_full  = (n_af_act - naf0 == 2) && (n_wd_act - nwd0 == 4) && (scnt < 20);
                        if (af_full) scnt++;
                    end
                    2: begin
                        af_full  = ($urandom % 4 == 0);
                        wdf_full = ($urandom % 4 == 0);
                    end
                    default: ;
                endcase
                rect_valid = 1'($urandom);
                rect_x0 = 10'($urandom); rect_y1 = 10'($urandom);
                @(posedge clk); #1;
                cyc++;
            end
            rect_valid = 1'b0;
            af_full    = 1'b0;
            wdf_full   = 1'b0;
            chk("done_within_budget", 128'(cyc < budget), 128'(1));
            if (cyc >= budget) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end else begin
                chk("ready_cycle_after_last_beat", 128'(cyc_g), 128'(last_push_cyc + 1));
            end
            if (mode == 1) chk("af_stall_cycles", 128'(scnt), 128'(20));
        end
        chk("push_count", 128'(act_q.size() - base), 128'(exp_q.size()));
        n = act_q.size() - base;
        if (n > exp_q.size()) n = exp_q.size();
        for (int i = 0; i < n; i++) chk_ev(i, act_q[base + i], exp_q[i]);
        chk("enable_vs_full", 128'(viol - v0), 128'(0));
    endtask

    vec_t vt[8];

    initial begin
        int base, naf, n_after, first_af, first_wd, v0, naf0, cyc;
        int x0, x1, y0, y1;

        vt[0] = '{0, 7, 0, 0, 24'hFF0000, 0, 1, 31'h0010_0000, 16'h0000};
        vt[1] = '{3, 10, 2, 2, 24'h123456, 0, 2, 31'h0010_0800, 16'h0FFF};
        vt[2] = '{0, 15, 0, 3, 24'h00AA55, 1, 8, 31'h0010_0000, 16'h0000};
        vt[3] = '{9, 4, 0, 0, 24'h777777, 0, 0, 31'h0, 16'h0};
        vt[4] = '{5, 5, 7, 7, 24'hC0FFEE, 0, 1, 31'h0010_1C00, 16'hFFFF};
        vt[5] = '{0, 7, 5, 4, 24'h010203, 0, 0, 31'h0, 16'h0};
`ifdef RECT_FILL_CLIP_EN
        vt[6] = '{1020, 1023, 1023, 1023, 24'h0000FF, 0, 0, 31'h0, 16'h0};
        vt[7] = '{790, 1000, 595, 700, 24'h00FF00, 2, 10, 31'h0019_4F10, 16'hFFFF};
`else
        vt[6] = '{1020, 1023, 1023, 1023, 24'h0000FF, 0, 1, 31'h001F_FFF8, 16'hFFFF};
        vt[7] = '{790, 1000, 595, 700, 24'h00FF00, 2, 2968, 31'h0019_4F10, 16'hFFFF};
`endif

        rst = 1'b1;
        rect_x0 = '0; rect_x1 = '0; rect_y0 = '0; rect_y1 = '0;
        rect_color = '0; rect_valid = 1'b0;
        af_full = 1'b0; wdf_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_ready", 128'(rect_ready), 128'(1));
        chk("rst_af_en", 128'(af_wr_en), 128'(0));
        chk("rst_wdf_en", 128'(wdf_wr_en), 128'(0));
        chk("rst_af_addr", 128'(af_addr_din), 128'(0));
        chk("rst_wdf_din", wdf_din, 128'(0));
        chk("rst_mask", 128'(wdf_mask_din), 128'(16'hFFFF));

        // Table vectors, issued back to back
        foreach (vt[k]) begin
            run_cmd(vt[k].x0, vt[k].x1, vt[k].y0, vt[k].y1, vt[k].col, vt[k].mode, base);
            naf = 0; first_af = -1; first_wd = -1;
            for (int i = base; i < act_q.size(); i++) begin
                if (!act_q[i].is_wd) begin
                    naf++;
                    if (first_af < 0) first_af = i;
                end else if (first_wd < 0) first_wd = i;
            end
            chk($sformatf("tbl%0d_af_count", k), 128'(naf), 128'(vt[k].n_af));
            if (vt[k].n_af > 0 && first_af >= 0 && first_wd >= 0) begin
                chk($sformatf("tbl%0d_first_addr", k), 128'(act_q[first_af].addr), 128'(vt[k].first_addr));
                chk($sformatf("tbl%0d_first_mask", k), 128'(act_q[first_wd].mask), 128'(vt[k].first_mask));
            end
        end

        // Reset during row 1 of a 64x10 fill
        build_exp(0, 63, 0, 9, 24'hABCDEF);
        base = act_q.size();
        naf0 = n_af_act;
        rect_x0 = 10'd0; rect_x1 = 10'd63; rect_y0 = 10'd0; rect_y1 = 10'd9;
        rect_color = 24'hABCDEF;
        rect_valid = 1'b1;
        @(posedge clk); #1;
        rect_valid = 1'b0;
        cyc = 0;
        while (n_af_act - naf0 < 10 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("midfill_reached_row1", 128'(cyc < 200), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_after = act_q.size();
        chk("midrst_ready", 128'(rect_ready), 128'(1));
        chk("midrst_af_en", 128'(af_wr_en), 128'(0));
        chk("midrst_wdf_en", 128'(wdf_wr_en), 128'(0));
        chk("midrst_af_addr", 128'(af_addr_din), 128'(0));
        chk("midrst_wdf_din", wdf_din, 128'(0));
        chk("midrst_mask", 128'(wdf_mask_din), 128'(16'hFFFF));
        for (int i = 0; i < n_after - base && i < exp_q.size(); i++)
            chk_ev(i, act_q[base + i], exp_q[i]);
        repeat (10) @(posedge clk);
        #1;
        chk("no_push_after_reset", 128'(act_q.size() - n_after), 128'(0));
        chk("idle_after_reset", 128'(rect_ready), 128'(1));
        run_cmd(0, 7, 0, 0, 24'hFF0000, 0, base);

        // Randomised commands against the reference
        for (int r = 0; r < 30; r++) begin
            x0 = $urandom_range(0, 900);
            x1 = x0 + $urandom_range(0, 40);
            if (x1 > 1023) x1 = 1023;
            y0 = $urandom_range(0, 700);
            y1 = y0 + $urandom_range(0, 2);
            if ($urandom % 8 == 0 && x0 > 0) x1 = x0 - 1;
            run_cmd(x0, x1, y0, y1, 24'($urandom), (r % 2 == 0) ? 2 : 0, base);
        end

        v0 = n_pass;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        if (v0 < 0) $display("unreachable");
        $finish;
    end

endmodule
